or_test: RTL and testbench

Bitwise-OR unit for the BinaryLogic group of the step-2 datapath. It presents a purely combinational `result = a | b` and also a registered copy with a valid flag. The registered side carries status flags and an optional sticky OR-accumulator. The block sits beside the AND/XOR units and is fed directly by operand registers.

---
 rtl/binlogic_pkg.sv | 11 +
 rtl/or_test_popcount.sv | 30 +++
 rtl/or_test.sv | 74 +++++++
 tb/tb_or_test.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/binlogic_pkg.sv
// Shared constants and helpers for the BinaryLogic units (AND/OR/XOR).
package binlogic_pkg;

  localparam int WIDTH_DEF = 4;

  // Bits needed to hold a count of 0..width set bits.
  function automatic int POP_W(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/or_test_popcount.sv
// Combinational set-bit counter built as a recursive halving adder tree.
module popcount
  import binlogic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]        in,
  output logic [POP_W(WIDTH)-1:0] cnt
);

  localparam int PW = POP_W(WIDTH);

  generate
    if (WIDTH == 1) begin : g_leaf
      assign cnt = in;
    end else begin : g_node
      localparam int LO = WIDTH / 2;
      localparam int HI = WIDTH - LO;

      logic [POP_W(LO)-1:0] cnt_lo;
      logic [POP_W(HI)-1:0] cnt_hi;

      popcount #(.WIDTH(LO)) u_lo (.in(in[LO-1:0]),     .cnt(cnt_lo));
      popcount #(.WIDTH(HI)) u_hi (.in(in[WIDTH-1:LO]), .cnt(cnt_hi));

      assign cnt = PW'(cnt_lo) + PW'(cnt_hi);
    end
  endgenerate

endmodule

// File: rtl/or_test.sv
// Bitwise-OR unit: combinational result plus a registered copy with status
// flags, valid pulse and a sticky OR-accumulator.
module or_test
  import binlogic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  input  logic                    in_valid,
  input  logic                    acc_en,
  input  logic                    acc_clr,
  output logic [WIDTH-1:0]        result,
  output logic [WIDTH-1:0]        result_q,
  output logic                    out_valid,
  output logic                    zero_q,
  output logic                    ones_q,
  output logic [POP_W(WIDTH)-1:0] pop_q,
  output logic [WIDTH-1:0]        acc_q
);

  localparam int PW     = POP_W(WIDTH);
  localparam int STAGES = 1;

  logic [WIDTH-1:0] nxt;
  logic [PW-1:0]    pop_nxt;
  logic [STAGES:0]  vld_pipe;

  assign nxt    = a | b;
  assign result = nxt;

  popcount #(.WIDTH(WIDTH)) u_pop (.in(nxt), .cnt(pop_nxt));

  // Stage 0 is the live input; the registered stages drop any beat on reset.
  assign vld_pipe[0] = in_valid;
  assign out_valid   = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end
  end

  // Flags are derived from the next-state value so they line up with result_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      ones_q   <= 1'b0;
      pop_q    <= '0;
    end else if (in_valid) begin
      result_q <= nxt;
      zero_q   <= (nxt == '0);
      ones_q   <= (nxt == '1);
      pop_q    <= pop_nxt;
    end
  end

  // Clear wins over accumulation of a same-cycle beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (acc_clr) begin
      acc_q <= '0;
    end else if (in_valid && acc_en) begin
      acc_q <= acc_q | nxt;
    end
  end

endmodule

// File: tb/tb_or_test.sv
// Scoreboard bench for or_test: stimulus pushes per-cycle expectations from a
// behavioural model, a monitor pops and compares after each rising edge.
module tb_or_test;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         in_valid, acc_en, acc_clr;
  logic [W-1:0] result, result_q, acc_q;
  logic         out_valid, zero_q, ones_q;
  logic [2:0]   pop_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         v;
    logic [W-1:0] res;
    logic [W-1:0] acc;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_acc = '0;

  or_test #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .acc_en(acc_en), .acc_clr(acc_clr), .result(result), .result_q(result_q),
    .out_valid(out_valid), .zero_q(zero_q), .ones_q(ones_q), .pop_q(pop_q),
    .acc_q(acc_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst result_q", result_q, 0);
    chk("rst acc_q", acc_q, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst pop_q", pop_q, 0);
    chk("rst ones_q", ones_q, 0);
    chk("rst zero_q", zero_q, 1);
  endtask

  // One cycle of stimulus; the model computes what the edge should produce.
  task automatic beat(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic en, input logic clr);
    exp_t e;
    @(negedge clk);
    in_valid = v; a = ta; b = tb; acc_en = en; acc_clr = clr;
    #1 chk("comb result", result, ta | tb);
    if (v) m_res = ta | tb;
    if (clr) m_acc = '0;
    else if (v && en) m_acc = m_acc | ta | tb;
    e.v = v; e.res = m_res; e.acc = m_acc;
    sb.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_valid", out_valid, e.v);
        chk("result_q", result_q, e.res);
        chk("zero_q", zero_q, e.res == 0);
        chk("ones_q", ones_q, &e.res);
        chk("pop_q", pop_q, $countones(e.res));
        chk("acc_q", acc_q, e.acc);
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 0; acc_en = 0; acc_clr = 0;
    a = 4'b1001; b = 4'b0101;
    #10 chk("comb in reset 1", result, 4'b1101);
    a = 4'b0011; b = 4'b1100;
    #10 chk("comb in reset 2", result, 4'b1111);
    chk_reset_vals();

    @(negedge clk);
    rst_n = 1'b1;

    // Directed beats
    beat(1, 4'b1001, 4'b0101, 0, 0);
    beat(0, 4'b0000, 4'b0000, 0, 0);
    beat(1, 4'b0000, 4'b0000, 0, 0);
    beat(1, 4'b0011, 4'b1100, 0, 0);
    beat(0, 4'b1111, 4'b0000, 1, 0);
    // Accumulator sequence, then clear colliding with an accumulate beat
    beat(1, 4'b0001, 4'b0000, 1, 0);
    beat(1, 4'b0000, 4'b0010, 1, 0);
    beat(1, 4'b1000, 4'b1000, 1, 0);
    beat(0, 4'b0000, 4'b0000, 0, 0);
    beat(1, 4'b0100, 4'b0000, 1, 1);
    beat(1, 4'b0110, 4'b0000, 1, 0);

    // Random traffic
    for (int i = 0; i < 300; i++)
      beat(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
           1'($urandom), 1'($urandom_range(0, 9) == 0));

    // Reset with acc_q non-zero and a beat in flight
    beat(1, 4'b1010, 4'b0001, 1, 0);
    beat(1, 4'b0100, 4'b0000, 1, 0);
    @(negedge clk);
    in_valid = 1; acc_en = 1; acc_clr = 0; a = 4'b0110; b = 4'b0001;
    #2 rst_n = 1'b0;
    sb.delete();
    m_res = '0; m_acc = '0;
    #1 chk_reset_vals();
    chk("comb during reset", result, 4'b0111);
    a = 4'b1000; b = 4'b0010;
    #1 chk("comb track reset", result, 4'b1010);
    repeat (2) @(posedge clk);
    #1 chk_reset_vals();
    @(negedge clk);
    in_valid = 0;
    rst_n = 1'b1;

    beat(1, 4'b0010, 4'b0001, 1, 0);
    beat(0, 4'b0000, 4'b0000, 0, 0);
    for (int i = 0; i < 50; i++)
      beat(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0));
    beat(0, 4'b0000, 4'b0000, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
